// File: rtl/ltl_automata_engine.sv
// rtl/ltl_automata_engine.sv - homogeneous STE automata engine with report FIFO
// Symbol-at-a-time NFA: STE activation, start-all/start-of-data injection, report queue.
module ltl_automata_engine #(
  parameter int N_STE      = 16,
  parameter int SYM_W      = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       cfg_we,
  input  logic [1:0]                 cfg_sel,
  input  logic [$clog2(N_STE)-1:0]   cfg_idx,
  input  logic [2**SYM_W-1:0]        cfg_data,
  input  logic [N_STE-1:0]           rpt_mask,
  input  logic                       run,
  input  logic                       start,
  input  logic                       sym_valid,
  output logic                       sym_ready,
  input  logic [SYM_W-1:0]           symbols,
  output logic [N_STE-1:0]           active_states,
  output logic                       rpt_valid,
  input  logic                       rpt_ready,
  output logic [N_STE-1:0]           rpt_vector,
  output logic [CNT_W-1:0]           rpt_offset
);

  localparam int SYMS = 2**SYM_W;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [SYMS-1:0]  match_q [N_STE];
  logic [N_STE-1:0] edge_q  [N_STE];
  logic [N_STE-1:0] start_all_q, start_sod_q;

  logic [N_STE-1:0] active_q, active_d, enable, hits;
  logic             first_q;
  logic [CNT_W-1:0] off_q;

  logic [N_STE-1:0] fvec_q [FIFO_DEPTH];
  logic [CNT_W-1:0] foff_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;

  logic cfg_wr, idx_ok, accept, push, pop;

  assign cfg_wr    = cfg_we & ~run;
  assign idx_ok    = (32'(cfg_idx) < N_STE);
  assign sym_ready = reset_n & run & ~start & (cnt_q < DEPTH_C);
  assign accept    = sym_valid & sym_ready;
  assign rpt_valid = (cnt_q != '0);
  assign pop       = rpt_valid & rpt_ready;
  assign hits      = active_d & rpt_mask;
  // sym_ready already excludes the full case, so a push never meets a full FIFO.
  assign push      = accept & (|hits);

  assign active_states = active_q;
  assign rpt_vector    = fvec_q[rd_q];
  assign rpt_offset    = foff_q[rd_q];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < N_STE; i++) begin
        match_q[i] <= '0;
        edge_q[i]  <= '0;
      end
      start_all_q <= '0;
      start_sod_q <= '0;
    end else if (cfg_wr) begin
      case (cfg_sel)
        2'd0: if (idx_ok) match_q[cfg_idx] <= cfg_data;
        2'd1: if (idx_ok) edge_q[cfg_idx] <= cfg_data[N_STE-1:0];
        2'd2: start_all_q <= cfg_data[N_STE-1:0];
        default: start_sod_q <= cfg_data[N_STE-1:0];
      endcase
    end
  end

  always_comb begin
    enable = start_all_q | (start_sod_q & {N_STE{first_q}});
    for (int i = 0; i < N_STE; i++) begin
      if (active_q[i]) enable = enable | edge_q[i];
    end
    active_d = '0;
    for (int j = 0; j < N_STE; j++) begin
      active_d[j] = enable[j] & match_q[j][symbols];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || start) begin
      active_q <= '0;
      off_q    <= '0;
      first_q  <= 1'b1;
    end else if (accept) begin
      active_q <= active_d;
      off_q    <= off_q + CNT_W'(1);
      first_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fvec_q[wr_q] <= hits;
      foff_q[wr_q] <= off_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: doc/ltl_automata_engine.md
LTL_AUTOMATA_ENGINE -- requirements
Module: ltl_automata_engine

Interface
REQ-001 SHALL have parameter N_STE, default 16: number of STEs; legal range 2..2**SYM_W.
REQ-002 SHALL have parameter SYM_W, default 8: symbol width in bits.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: report FIFO entries; must be a power of two and at least 2.
REQ-004 SHALL have parameter CNT_W, default 32: width of the symbol offset counter.
REQ-005 SHALL have one clock, clk, and one reset, reset_n; reset is synchronous and active-low.
REQ-006 clk  in  1  rising-edge clock for all state.
REQ-007 reset_n  in  1  synchronous active-low reset.
REQ-008 cfg_we  in  1  configuration write strobe.
REQ-009 cfg_sel  in  2  target: 0 match row, 1 edge row, 2 start-all mask, 3 start-of-data mask.
REQ-010 cfg_idx  in  $clog2(N_STE)  STE row index, used when cfg_sel is 0 or 1.
REQ-011 cfg_data  in  2**SYM_W  row data; masks and edge rows use bits [N_STE-1:0].
REQ-012 rpt_mask  in  N_STE  static mask of reporting STEs.
REQ-013 run  in  1  enables symbol consumption.
REQ-014 start  in  1  single-cycle pulse that begins a new stream.
REQ-015 sym_valid / sym_ready  in / out  1 / 1  symbol handshake.
REQ-016 symbols  in  SYM_W  input symbol.
REQ-017 active_states  out  N_STE  registered STE activation vector.
REQ-018 rpt_valid / rpt_ready  out / in  1 / 1  report handshake.
REQ-019 rpt_vector, rpt_offset  out  N_STE, CNT_W  head-of-FIFO report entry.

Function
REQ-020 cfg_we SHALL take effect only while run=0; a write with run=1 SHALL be ignored.
REQ-021 A match-row write SHALL set match[cfg_idx][s]=cfg_data[s] for every symbol s.
REQ-022 An edge-row write SHALL set edge[cfg_idx][j]=cfg_data[j]; edge[i][j]=1 means STE i enables STE j.
REQ-023 sym_ready SHALL equal run & ~start & (fifo_count < FIFO_DEPTH).
REQ-024 A symbol SHALL be accepted only on a cycle with sym_valid & sym_ready; in all other cycles active_states, first, and the offset SHALL hold.
REQ-025 On accept, enable[j] SHALL equal OR_i(active[i] & edge[i][j]) | start_all[j] | (start_sod[j] & first).
REQ-026 On accept, active_states[j] SHALL take enable[j] & match[j][symbols], registered, visible 1 cycle after accept.
REQ-027 first SHALL be 1 after reset and after start, and SHALL clear on the first accepted symbol.
REQ-028 The offset SHALL count accepted symbols from 0 since reset or start, and SHALL wrap modulo 2**CNT_W.
REQ-029 On accept, if hits = next active & rpt_mask is nonzero, {hits, offset of this symbol} SHALL be pushed to the FIFO.
REQ-030 The pushed entry SHALL reach rpt_* no earlier than 1 cycle after accept.
REQ-031 An all-zero hits vector SHALL never be pushed.
REQ-032 rpt_valid SHALL equal ~fifo_empty, and an entry SHALL pop on rpt_valid & rpt_ready.
REQ-033 rpt_vector and rpt_offset SHALL stay stable while rpt_valid=1 and rpt_ready=0.
REQ-034 A simultaneous push and pop SHALL leave fifo_count unchanged, including when the FIFO is full.
REQ-035 The FIFO SHALL be first-in first-out, with no loss and no duplication.
REQ-036 start SHALL clear active_states and the offset and set first=1 on the next edge; FIFO contents SHALL be retained.

Reset
REQ-037 With reset_n=0 at a clk edge, the block SHALL clear all match, edge, and start tables.
REQ-038 With reset_n=0 at a clk edge, the block SHALL set active_states=0, offset=0, first=1, FIFO empty, and rpt_valid=0.
REQ-039 While reset_n=0, sym_ready SHALL be 0.
REQ-040 Reset asserted mid-stream SHALL discard in-flight state and queued reports in the same edge.

Verification
REQ-041 Bench SHALL cover sequence detect: N_STE=4; STE0 match 0x41, start-of-data; edge 0->1; STE1 match 0x42; rpt_mask=0010; stream 0x41,0x42 -> one report {0010, offset 1}.
REQ-042 Bench SHALL cover start-of-data gating: same configuration, stream 0x43,0x41,0x42 -> no report; then start and 0x41,0x42 -> report {0010, offset 1}.
REQ-043 Bench SHALL cover all-input mode: STE0 start-all; stream 0x41,0x42,0x41,0x42 -> reports at offsets 1 and 3.
REQ-044 Bench SHALL cover backpressure: FIFO_DEPTH=2, rpt_ready=0, 3 report-producing symbols -> sym_ready=0 after the 2nd push; raising rpt_ready -> the 3rd is accepted and order is preserved.
REQ-045 Bench SHALL cover ignored configuration and mid-stream reset: a cfg_we write with run=1 leaves the tables unchanged; reset_n=0 mid-stream -> active_states=0, rpt_valid=0, offset=0 on the next cycle.
REQ-046 Bench SHALL cover offset wrap: CNT_W=4, 17 accepted symbols with STE0 start-all matching every symbol and reporting -> offsets 0..15, then 0.
